// File: rtl/otp_pkg.sv
// Shared definitions for the OTP program sequencer and the OTP array controller.
package otp_pkg;

  localparam logic [1:0] MODE_READING = 2'b00;
  localparam logic [1:0] MODE_WRITING = 2'b01;
  localparam logic [1:0] MODE_IDLE    = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_WR_WAIT,
    S_GAP_R,
    S_RD,
    S_RD_WAIT,
    S_CMP,
    S_RETRY,
    S_NEXT,
    S_DONE,
    S_ERR
  } seq_state_t;

endpackage

// File: rtl/otp_program_sequencer_if.sv
// Command/response bundle between the program sequencer (master) and the OTP controller (slave).
interface otp_program_sequencer_if #(
  parameter int A          = 2,
  parameter int ADDR_WIDTH = 1
);

  logic [1:0]            ctrl_mode;
  logic [ADDR_WIDTH-1:0] ctrl_column;
  logic [A-1:0]          ctrl_data_in;
  logic                  ctrl_writing_successful;
  logic                  ctrl_read_active;
  logic [A-1:0]          ctrl_data_out;

  modport master (
    output ctrl_mode, ctrl_column, ctrl_data_in,
    input  ctrl_writing_successful, ctrl_read_active, ctrl_data_out
  );

  modport slave (
    input  ctrl_mode, ctrl_column, ctrl_data_in,
    output ctrl_writing_successful, ctrl_read_active, ctrl_data_out
  );

endinterface

// File: rtl/otp_wait_timer.sv
// Saturating wait-cycle counter; expired is high once TIMEOUT-1 enabled cycles have elapsed since clear.
module otp_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/otp_program_sequencer.sv
// Programs an A x B image into the OTP array column by column, read-verifying each column,
// retrying recoverable mismatches/timeouts and reporting done or a sticky error.
module otp_program_sequencer
  import otp_pkg::*;
#(
  parameter int A          = 2,
  parameter int B          = 2,
  parameter int ADDR_WIDTH = $clog2(B),
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [A*B-1:0]        img_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] fail_col,
  otp_program_sequencer_if.master ctrl
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  seq_state_t            state, state_n;
  logic [A*B-1:0]        image_reg, image_n;
  logic [ADDR_WIDTH-1:0] col, col_n;
  logic [RW-1:0]         retry, retry_n;
  logic [A-1:0]          rd_reg, rd_n;
  logic [A-1:0]          expected;
  logic [1:0]            mode_q, mode_n;
  logic [ADDR_WIDTH-1:0] column_q, column_n;
  logic [A-1:0]          data_in_q, data_in_n;
  logic                  busy_n, done_n, error_n;
  logic [ADDR_WIDTH-1:0] fail_col_n;
  logic                  tmr_clear, tmr_en, tmr_expired;

  assign expected = image_reg[int'(col) * A +: A];

  assign ctrl.ctrl_mode    = mode_q;
  assign ctrl.ctrl_column  = column_q;
  assign ctrl.ctrl_data_in = data_in_q;

  otp_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_n    = state;
    image_n    = image_reg;
    col_n      = col;
    retry_n    = retry;
    rd_n       = rd_reg;
    mode_n     = MODE_IDLE;
    column_n   = column_q;
    data_in_n  = data_in_q;
    busy_n     = busy;
    done_n     = 1'b0;
    error_n    = error;
    fail_col_n = fail_col;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          image_n    = img_data;
          col_n      = '0;
          retry_n    = '0;
          error_n    = 1'b0;
          fail_col_n = '0;
          state_n    = S_WR;
        end
      end
      // busy is raised alongside the first write command so both appear on the same edge.
      S_WR: begin
        mode_n    = MODE_WRITING;
        column_n  = col;
        data_in_n = expected;
        busy_n    = 1'b1;
        tmr_clear = 1'b1;
        state_n   = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        mode_n = mode_q;
        tmr_en = 1'b1;
        if (ctrl.ctrl_writing_successful) state_n = S_GAP_R;
        else if (tmr_expired)             state_n = S_RETRY;
      end
      S_GAP_R: state_n = S_RD;
      S_RD: begin
        mode_n    = MODE_READING;
        column_n  = col;
        tmr_clear = 1'b1;
        state_n   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mode_n = mode_q;
        tmr_en = 1'b1;
        if (ctrl.ctrl_read_active) begin
          rd_n    = ctrl.ctrl_data_out;
          state_n = S_CMP;
        end else if (tmr_expired) begin
          state_n = S_RETRY;
        end
      end
      // A bit already blown to 1 where 0 is wanted cannot be undone by rewriting.
      S_CMP: begin
        if (rd_reg == expected)           state_n = S_NEXT;
        else if (|(rd_reg & ~expected))   state_n = S_ERR;
        else                              state_n = S_RETRY;
      end
      S_RETRY: begin
        if (retry < RW'(MAX_RETRY)) begin
          retry_n = retry + RW'(1);
          state_n = S_WR;
        end else begin
          state_n = S_ERR;
        end
      end
      S_NEXT: begin
        if (col == ADDR_WIDTH'(B - 1)) begin
          state_n = S_DONE;
        end else begin
          col_n   = col + ADDR_WIDTH'(1);
          retry_n = '0;
          state_n = S_WR;
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      S_ERR: begin
        error_n    = 1'b1;
        fail_col_n = col;
        busy_n     = 1'b0;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      image_reg <= '0;
      col       <= '0;
      retry     <= '0;
      rd_reg    <= '0;
      mode_q    <= MODE_IDLE;
      column_q  <= '0;
      data_in_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      fail_col  <= '0;
    end else begin
      state     <= state_n;
      image_reg <= image_n;
      col       <= col_n;
      retry     <= retry_n;
      rd_reg    <= rd_n;
      mode_q    <= mode_n;
      column_q  <= column_n;
      data_in_q <= data_in_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      fail_col  <= fail_col_n;
    end
  end

endmodule
